instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Single-cycle fetch stage that owns the program counter, issues requests to a synchronous-read instruction memory, and presents fetched 32-bit instructions with their PC to the decoder over a valid/ready handshake. It sits directly upstream of the instruction field parser. It absorbs the one-cycle memory latency with a 2-entry buffer and accepts PC redirects from branch/jump resolution, flushing stale fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; low 2 bits must be 0
- NOP_INSTR, 32'h0000_0013, value driven on `instruction` whenever `inst_valid`=0 (addi x0,x0,0)

- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- imem_en  output  1  instruction memory read request this cycle
- imem_addr  output  32  byte address of the request, always 4-aligned
- imem_rdata  input  32  memory data, valid exactly one cycle after a cycle with imem_en=1
- redirect_valid  input  1  load new PC this cycle (taken branch/jump)
- redirect_pc  input  32  target PC; bits [1:0] ignored, treated as 0
- inst_valid  output  1  buffer head holds a valid instruction
- inst_ready  input  1  decoder accepts head this cycle
- instruction  output  32  head instruction word (NOP_INSTR when invalid)
- inst_pc  output  32  PC of head instruction (0 when invalid)

## Operation
- State: fetch_pc (32), pending (1, response due next cycle), pending_pc (32), 2-entry FIFO of {instr, pc}, count (0..2).
- pop = inst_valid & inst_ready; FIFO head advances on pop.
- Issue rule: imem_en = !redirect_valid & ((count + pending - pop) < 2). imem_addr = fetch_pc. On issue: pending<=1, pending_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- Response: when pending=1, {imem_rdata, pending_pc} is pushed into the FIFO at the clock edge; pending clears unless a new issue occurs in the same cycle.
- Issue rule guarantees no overflow; push and pop in the same cycle are legal at any count, including count=2 with a pop.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- Redirect (cycle t): FIFO cleared (count<=0), any response arriving in cycle t discarded, pending<=0, fetch_pc<={redirect_pc[31:2],2'b00}, imem_en=0 in t. Fetch resumes at t+1 from the new PC. A pop in cycle t is still considered accepted by the decoder. Redirect has priority over push.
- Back-to-back redirects: each one overrides the previous; only the last target is fetched.
- Reset, at any time including mid-fetch: fetch_pc<=RESET_PC, pending<=0, count<=0. Outputs: imem_en=0, imem_addr=RESET_PC, inst_valid=0, instruction=NOP_INSTR, inst_pc=0. A response that arrives after rst drops is ignored because pending=0.

## Timing
- First cycle with rst=0: imem_en=1, imem_addr=RESET_PC.
- Fetch latency: request in cycle n, imem_rdata sampled in n+1, inst_valid=1 in n+2.
- Throughput: one instruction per cycle in steady state when inst_ready is held high.
- Redirect penalty: redirect in t, new request in t+1, first new instruction valid in t+3.
- instruction/inst_pc are registered FIFO-head outputs, stable while inst_valid=1 and inst_ready=0.
- imem_en depends combinationally on inst_ready and redirect_valid. No other input-to-output combinational paths.

## Test plan
- Reset then free run with imem_rdata = addr-based pattern and inst_ready=1 -> imem_addr 0,4,8,...; inst_valid rises 2 cycles after first request; inst_pc 0,4,8 back-to-back with matching words.
- Backpressure: inst_ready=0 for 5 cycles mid-stream -> count saturates at 2; imem_en low after 2 outstanding; no instruction lost or duplicated after ready returns.
- Redirect to 32'h0000_0100 while FIFO full and response pending -> inst_valid=0 next cycle; next request address 0x100; first delivered inst_pc=0x100 at t+3; stale words never appear.
- Misaligned redirect_pc 32'h0000_0203 -> fetch address 0x200.
- Wrap-around: redirect to 32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset asserted mid-stream, between clock edges -> outputs go to reset values immediately; after release, fetch restarts at RESET_PC; the late memory response is dropped.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and fetch stage with 2-entry response buffer
// Issues sync-read imem requests, buffers {instr, pc}, hands them to the decoder over valid/ready.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  logic [31:0] fetch_pc;
  logic        pending;
  logic [31:0] pending_pc;
  logic [1:0]  count;
  logic [31:0] head_instr;
  logic [31:0] head_pc;
  logic [31:0] tail_instr;
  logic [31:0] tail_pc;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid & inst_ready;
  assign push       = pending & ~redirect_valid;

  // Slots already claimed after this edge; a new request is only allowed if its
  // response is guaranteed a free entry, so the buffer can never overflow.
  assign occupancy = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
  assign issue     = ~rst & ~redirect_valid & (occupancy < 3'd2);

  assign imem_en     = issue;
  assign imem_addr   = fetch_pc;
  assign instruction = head_instr;
  assign inst_pc     = head_pc;

  // Head registers are forced to NOP/0 whenever the buffer is empty so the
  // decoder-facing outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= 32'd0;
      count      <= 2'd0;
      head_instr <= NOP_INSTR;
      head_pc    <= 32'd0;
      tail_instr <= NOP_INSTR;
      tail_pc    <= 32'd0;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      pending    <= 1'b0;
      count      <= 2'd0;
      head_instr <= NOP_INSTR;
      head_pc    <= 32'd0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end

      case (count)
        2'd0: begin
          if (push) begin
            head_instr <= imem_rdata;
            head_pc    <= pending_pc;
            count      <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_instr <= imem_rdata;
            head_pc    <= pending_pc;
          end else if (push) begin
            tail_instr <= imem_rdata;
            tail_pc    <= pending_pc;
            count      <= 2'd2;
          end else if (pop) begin
            head_instr <= NOP_INSTR;
            head_pc    <= 32'd0;
            count      <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            if (push) begin
              tail_instr <= imem_rdata;
              tail_pc    <= pending_pc;
              count      <= 2'd2;
            end else begin
              count      <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vector bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  int checks;
  int errors;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word is the bitwise inverse of its address; idle cycles return junk.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= ~imem_addr;
    else         imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic en, input logic [31:0] addr,
                           input logic valid, input logic [31:0] pc);
    logic [31:0] exp_instr;
    exp_instr = valid ? ~pc : NOP;
    check({tag, " imem_en"},     {31'd0, imem_en},    {31'd0, en});
    check({tag, " imem_addr"},   imem_addr,           addr);
    check({tag, " inst_valid"},  {31'd0, inst_valid}, {31'd0, valid});
    check({tag, " inst_pc"},     inst_pc,             valid ? pc : 32'd0);
    check({tag, " instruction"}, instruction,         exp_instr);
  endtask

  task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic en, input logic [31:0] addr,
                     input logic valid, input logic [31:0] pc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.en = en; v.addr = addr; v.valid = valid; v.pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    inst_ready = 1'b1;

    //  rv  rpc            rdy  en  addr           valid pc
    add(0, 32'h0,          1,   1, 32'h0000_0000, 0, 32'h0);           // first request
    add(0, 32'h0,          1,   1, 32'h0000_0004, 0, 32'h0);
    add(0, 32'h0,          1,   1, 32'h0000_0008, 1, 32'h0000_0000);   // valid 2 cycles later
    add(0, 32'h0,          1,   1, 32'h0000_000C, 1, 32'h0000_0004);
    add(0, 32'h0,          0,   0, 32'h0000_0010, 1, 32'h0000_0008);   // backpressure x5
    add(0, 32'h0,          0,   0, 32'h0000_0010, 1, 32'h0000_0008);
    add(0, 32'h0,          0,   0, 32'h0000_0010, 1, 32'h0000_0008);
    add(0, 32'h0,          0,   0, 32'h0000_0010, 1, 32'h0000_0008);
    add(0, 32'h0,          0,   0, 32'h0000_0010, 1, 32'h0000_0008);
    add(0, 32'h0,          1,   1, 32'h0000_0010, 1, 32'h0000_0008);
    add(0, 32'h0,          1,   1, 32'h0000_0014, 1, 32'h0000_000C);
    add(0, 32'h0,          1,   1, 32'h0000_0018, 1, 32'h0000_0010);
    add(1, 32'h0000_0100,  1,   0, 32'h0000_001C, 1, 32'h0000_0014);   // redirect, response pending
    add(0, 32'h0,          1,   1, 32'h0000_0100, 0, 32'h0);
    add(0, 32'h0,          1,   1, 32'h0000_0104, 0, 32'h0);
    add(0, 32'h0,          1,   1, 32'h0000_0108, 1, 32'h0000_0100);   // t+3
    add(1, 32'h0000_0203,  0,   0, 32'h0000_010C, 1, 32'h0000_0104);   // misaligned redirect
    add(1, 32'hFFFF_FFF8,  1,   0, 32'h0000_0200, 0, 32'h0);           // back-to-back redirect
    add(0, 32'h0,          1,   1, 32'hFFFF_FFF8, 0, 32'h0);
    add(0, 32'h0,          1,   1, 32'hFFFF_FFFC, 0, 32'h0);
    add(0, 32'h0,          1,   1, 32'h0000_0000, 1, 32'hFFFF_FFF8);   // wrap
    add(0, 32'h0,          1,   1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
    add(0, 32'h0,          1,   1, 32'h0000_0008, 1, 32'h0000_0000);
    add(0, 32'h0,          1,   1, 32'h0000_000C, 1, 32'h0000_0004);

    @(negedge clk);
    @(negedge clk);
    #1;
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0);

    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      inst_ready     = vecs[i].rdy;
      #1;
      check_all($sformatf("v%0d", i), vecs[i].en, vecs[i].addr, vecs[i].valid, vecs[i].pc);
    end

    // Async reset pulse between edges while a response is still in flight.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    #1 rst = 1'b0;

    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    #1;
    check_all("post_rst0", 1'b1, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    check_all("post_rst1", 1'b1, 32'h4, 1'b0, 32'h0);   // late response dropped
    @(negedge clk);
    #1;
    check_all("post_rst2", 1'b1, 32'h8, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
